// File: rtl/tt_arb_pkg.sv
// Shared types and helpers for the round-robin lane arbiter.
package tt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_e;

  // $clog2 that never returns 0, so single-entry fields still get one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_rr_pin_arbiter_rr_pick.sv
// Circular first-one search starting at ptr; purely combinational.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N_REQ-1:0] masked;

  // Lower copy has bits below ptr masked off, so the lowest set bit of the
  // doubled vector is the first requester at or after ptr, wrapping around.
  always_comb begin
    masked = {req_i, req_i};
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (i < int'(ptr_i)) masked[i] = 1'b0;
    end
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 2 * int'(N_REQ) - 1; i >= 0; i--) begin
      if (masked[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((i >= int'(N_REQ)) ? i - int'(N_REQ) : i);
      end
    end
  end

endmodule

// File: rtl/tt_rr_pin_arbiter.sv
// Round-robin arbiter sharing one registered output lane between N_REQ
// requesters, with a per-grant hold limit that force-releases hogs.
module tt_rr_pin_arbiter
  import tt_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_W-1:0]       req_data,
  output logic [N_REQ-1:0]              gnt,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  output logic [clog2_min1(N_REQ)-1:0]  owner,
  output logic                          timeout_pulse
);

  localparam int unsigned OwnerW  = clog2_min1(N_REQ);
  localparam int unsigned HoldW   = clog2_min1(MAX_HOLD + 1);
  localparam int unsigned HoldLim = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [OwnerW-1:0]   owner_q, owner_d;
  logic [OwnerW-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic                timeout_q, timeout_d;

  logic                pick_found;
  logic [OwnerW-1:0]   pick_idx;
  logic                owner_req;
  logic [DATA_W-1:0]   owner_data;
  logic                limit_hit;
  logic [OwnerW-1:0]   ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (OwnerW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign owner_req  = req[owner_q];
  assign owner_data = req_data[owner_q*DATA_W +: DATA_W];
  assign limit_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HoldW'(HoldLim));
  assign ptr_next   = (owner_q == OwnerW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Next-state: arbitration in IDLE, hold tracking in GRANT, one-cycle gap in RELEASE.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d    = GRANT;
          gnt_d      = N_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        // Saturate so the counter can never wrap when the limit is disabled.
        if (hold_cnt_q != {HoldW{1'b1}}) hold_cnt_d = hold_cnt_q + 1'b1;
        if (!owner_req) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else if (limit_hit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          out_data_d  = owner_data;
          out_valid_d = 1'b1;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt           = gnt_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign owner         = owner_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_tt_rr_pin_arbiter.sv
// Self-checking bench: directed table, corner sequences, random vs. reference model.
module tb_tt_rr_pin_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [1:0]     owner;
  logic           timeout_pulse;

  tt_rr_pin_arbiter #(
    .N_REQ    (N),
    .DATA_W   (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .owner         (owner),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who holds the lane, for how long, and how much gap is left.
  bit           m_busy;
  int           m_owner;
  int           m_run;
  int           m_start;
  int           m_cool;
  logic [N-1:0] e_gnt;
  logic         e_valid;
  logic [W-1:0] e_data;
  logic         e_to;

  task automatic model_edge(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
    e_valid = 1'b0;
    e_data  = '0;
    e_to    = 1'b0;
    if (r) begin
      m_busy = 0; m_owner = 0; m_run = 0; m_start = 0; m_cool = 0;
      e_gnt = '0;
    end else if (m_busy) begin
      m_run++;
      if (!q[m_owner] || m_run == MH) begin
        e_to    = q[m_owner];
        m_busy  = 0;
        m_cool  = 1;
        m_start = (m_owner + 1) % N;
        e_gnt   = '0;
      end else begin
        e_valid = 1'b1;
        e_data  = d[m_owner*W +: W];
      end
    end else if (m_cool > 0) begin
      m_cool--;
      e_gnt = '0;
    end else begin
      e_gnt = '0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_start + k) % N;
        if (!m_busy && q[c]) begin
          m_busy  = 1;
          m_owner = c;
          m_run   = 0;
          e_gnt   = N'(1) << c;
        end
      end
    end
  endtask

  // Grant-stream recorder used by the multi-cycle sequences.
  int           rises[$];
  int           lens[$];
  int           gaps[$];
  int           to_cnt;
  int           cur_len;
  int           idle_cnt;
  bit           seen_fall;
  logic [N-1:0] prev_gnt;

  task automatic rec_clear();
    rises.delete(); lens.delete(); gaps.delete();
    to_cnt = 0; cur_len = 0; idle_cnt = 0; seen_fall = 0; prev_gnt = '0;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One clock: drive inputs, update model on the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
    rst = r; req = q; req_data = d;
    @(posedge clk);
    model_edge(r, q, d);
    #1;
    chk("m_gnt", 32'(gnt), 32'(e_gnt));
    chk("m_valid", 32'(out_valid), 32'(e_valid));
    chk("m_data", 32'(out_data), 32'(e_data));
    chk("m_owner", 32'(owner), 32'(m_owner));
    chk("m_timeout", 32'(timeout_pulse), 32'(e_to));
    if (gnt != '0) begin
      if (prev_gnt == '0) begin
        rises.push_back(oh_idx(gnt));
        chk("owner_at_grant", 32'(owner), 32'(oh_idx(gnt)));
        if (seen_fall) gaps.push_back(idle_cnt);
        cur_len = 0;
      end
      cur_len++;
    end else begin
      if (prev_gnt != '0) begin
        lens.push_back(cur_len);
        seen_fall = 1;
        idle_cnt  = 0;
      end
      idle_cnt++;
    end
    if (timeout_pulse) to_cnt++;
    prev_gnt = gnt;
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    rec_clear();
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] q;
    logic [N-1:0] x_gnt;
    logic         x_valid;
    logic [W-1:0] x_data;
    logic [1:0]   x_owner;
    logic         x_to;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [N-1:0]   rq;
    logic [N*W-1:0] rd;
    int             exp_order[5];
    int             lim;

    rst = 1'b1; req = '0; req_data = '0;
    rec_clear();

    // Single requester 0 then requester 1; lane data 0xA5 / 0x5A.
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0010, 4'b0010, 1'b0, 8'h00, 2'd1, 1'b0};
    vecs[8]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].r, vecs[i].q, 32'h0000_5AA5);
      chk($sformatf("t%0d_gnt", i), 32'(gnt), 32'(vecs[i].x_gnt));
      chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(vecs[i].x_valid));
      chk($sformatf("t%0d_data", i), 32'(out_data), 32'(vecs[i].x_data));
      chk($sformatf("t%0d_owner", i), 32'(owner), 32'(vecs[i].x_owner));
      chk($sformatf("t%0d_timeout", i), 32'(timeout_pulse), 32'(vecs[i].x_to));
    end

    // Round robin: all request, each owner drops for one cycle in its 3rd grant cycle.
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    rq = 4'b1111;
    lim = 0;
    while (rises.size() < 5 && lim < 60) begin
      rq = 4'b1111;
      if (m_busy && m_run == 2) rq[m_owner] = 1'b0;
      step(1'b0, rq, 32'h4433_2211);
      lim++;
    end
    chk("rr_grant_count", 32'(rises.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rises.size()) chk($sformatf("rr_order%0d", i), 32'(rises[i]), 32'(exp_order[i]));
      if (i < lens.size()) chk($sformatf("rr_len%0d", i), 32'(lens[i]), 32'd3);
      if (i < gaps.size()) chk($sformatf("rr_gap%0d", i), 32'(gaps[i]), 32'd2);
    end

    // Timeout: two requesters held constantly alternate every MAX_HOLD cycles.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b0, 4'b0011, 32'h0000_2211);
    chk("to_grants", 32'(rises.size()), 32'd3);
    chk("to_pulses", 32'(to_cnt), 32'd3);
    if (rises.size() == 3) begin
      chk("to_order0", 32'(rises[0]), 32'd0);
      chk("to_order1", 32'(rises[1]), 32'd1);
      chk("to_order2", 32'(rises[2]), 32'd0);
    end
    foreach (lens[i]) chk($sformatf("to_len%0d", i), 32'(lens[i]), 32'(MH));
    foreach (gaps[i]) chk($sformatf("to_gap%0d", i), 32'(gaps[i]), 32'd2);

    // Sole hog: one requester gets MAX_HOLD cycles, RELEASE, IDLE, repeatedly.
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b0, 4'b0100, 32'h0077_0000);
    chk("hog_grants", 32'(rises.size()), 32'd3);
    chk("hog_pulses", 32'(to_cnt), 32'd3);
    foreach (rises[i]) chk($sformatf("hog_who%0d", i), 32'(rises[i]), 32'd2);
    foreach (gaps[i]) chk($sformatf("hog_gap%0d", i), 32'(gaps[i]), 32'd2);

    // Owner drops req in the last allowed grant cycle: normal release, no pulse.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, 32'h0000_00C3);
    step(1'b0, 4'b0000, 32'h0000_00C3);
    chk("sim_gnt", 32'(gnt), 32'd0);
    chk("sim_timeout", 32'(timeout_pulse), 32'd0);
    step(1'b0, 4'b0000, '0);
    chk("sim_pulses", 32'(to_cnt), 32'd0);

    // Reset mid-grant, then only requester 3 asks.
    do_reset();
    step(1'b0, 4'b0100, 32'h003C_0000);
    step(1'b0, 4'b0100, 32'h003C_0000);
    chk("mid_data_before", 32'(out_data), 32'h3C);
    step(1'b1, 4'b0100, 32'h003C_0000);
    chk("mid_gnt", 32'(gnt), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_data", 32'(out_data), 32'd0);
    chk("mid_owner", 32'(owner), 32'd0);
    step(1'b0, 4'b1000, 32'h9900_0000);
    chk("post_gnt", 32'(gnt), 32'b1000);
    chk("post_owner", 32'(owner), 32'd3);

    // Randomized level-held requests with occasional resets.
    rq = '0;
    for (int i = 0; i < 400; i++) begin
      rq = rq ^ (N'($urandom) & N'($urandom));
      rd = (N * W)'($urandom);
      step(($urandom_range(0, 99) == 0), rq, rd);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Global bound so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/tt_rr_pin_arbiter.md
Name: tt_rr_pin_arbiter

Overview:
- Round-robin arbiter that shares one dedicated output lane (uo_out-style, DATA_W bits) between N_REQ on-chip requesters.
- Uses a req/gnt handshake with a per-grant hold-time limit, so no requester can starve the others.
- Sits between the requesting logic blocks and the tt_um top-level output assignment. It drives the registered lane data, a valid flag and the current owner index.

Parameters:
- N_REQ, 4, number of requesters (1..8).
- DATA_W, 8, width of the shared output lane.
- MAX_HOLD, 16, maximum consecutive GRANT cycles per grant; 0 disables the limit.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  request per requester, level-sensitive; held high while the lane is wanted.
- req_data  input  N_REQ*DATA_W  lane data per requester; slice i = req_data[i*DATA_W +: DATA_W].
- gnt  output  N_REQ  one-hot grant, registered.
- out_data  output  DATA_W  registered lane data from the owner; 0 when not valid.
- out_valid  output  1  registered; high while a grant is active.
- owner  output  $clog2(N_REQ) (min 1)  index of the current or last owner.
- timeout_pulse  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset values (all outputs and internal state, taken on the clk edge where rst=1):
  - gnt=0, out_data=0, out_valid=0, owner=0, timeout_pulse=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- Reset overrides everything, including an active grant: gnt drops on the reset edge.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If |req, select the first i with req[i]=1, searching circularly from ptr (ptr, ptr+1, ... wrapping at N_REQ).
  - Next edge: state=GRANT, gnt=1<<i, owner=i, hold_cnt=0.
  - If no request, stay in IDLE with all outputs 0 except owner, which holds its value.
- Latency: req rises in cycle t while IDLE -> gnt high at edge t+1.
- GRANT, evaluated every cycle:
  - out_data is registered from req_data[owner] and out_valid=1, so the lane lags the owner's data by one cycle. out_valid first rises on the edge after gnt rises.
  - hold_cnt increments by 1 each cycle.
  - If req[owner]=0: go to RELEASE (normal release).
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: go to RELEASE and assert timeout_pulse for exactly one cycle (forced release).
  - If both conditions hold in the same cycle, it is treated as a normal release; there is no timeout_pulse.
  - Requests from non-owners never affect the current grant.
- RELEASE (exactly one cycle):
  - gnt=0, out_valid=0, out_data=0.
  - ptr = (owner+1) mod N_REQ.
  - Next state is IDLE.
- Gap between grants: the minimum idle time between two grants is 2 cycles (RELEASE, then IDLE arbitration).
- Fairness:
  - After any release, the previous owner has the lowest priority.
  - A force-released requester still requesting is re-granted only after every other pending requester has been served. If it is the sole requester, it is re-granted after the 2-cycle gap.
- Glitch rule: req pulses shorter than one cycle, or a req that drops before being sampled in IDLE, produce no grant.
- hold_cnt width is $clog2(MAX_HOLD+1) and it never wraps; the forced release fires first.
- N_REQ=1: the arbiter degenerates to a grant/timeout gate; ptr stays 0.

Decomposition:
- Package tt_arb_pkg:
  - state enum arb_state_e {IDLE, GRANT, RELEASE}.
  - Function clog2_min1.
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector and ptr.
  - Outputs: found flag and the selected index, using a circular priority search (double-width mask trick).
- Top module: FSM, hold counter, output registers, data mux.

Test Plan:
- Single requester: rst 2 cycles, req=0001, req_data[0]=0xA5 -> gnt=0001 one cycle later; out_valid=1 and out_data=0xA5 on the following cycle; drop req -> RELEASE, gnt=0 and out_data=0.
- Round robin: req=1111 held, each requester drops req after 3 cycles then re-raises -> grant order 0,1,2,3,0; owner matches gnt each time; 2-cycle gap between grants.
- Timeout: MAX_HOLD=4, req=0011 held constantly -> req 0 granted 4 cycles, timeout_pulse one cycle, then req 1 granted, then req 0 again.
- Sole hog: MAX_HOLD=4, req=0100 only -> repeating pattern of 4 GRANT cycles, RELEASE, IDLE, with a timeout_pulse each period.
- Simultaneous release and limit: MAX_HOLD=4, owner drops req exactly in the 4th GRANT cycle -> RELEASE with timeout_pulse=0.
- Reset mid-grant: rst=1 during GRANT with out_data=0x3C -> next edge gnt=0, out_valid=0, out_data=0, owner=0; after rst drops, req=1000 with ptr=0 -> grant 3.
